// File: rtl/booth_r4_mult_seq.sv
// ---------------------------------------------------------------------------
// booth_r4_mult_seq
// Sequential signed radix-4 Booth multiplier. Two multiplier bits are retired
// per clock through a start/ready/valid handshake.
// Optional build macro: BOOTH_R4_UNSIGNED_EN adds the op_unsigned port, which
// selects an unsigned multiply taking one extra step.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module booth_r4_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
`ifdef BOOTH_R4_UNSIGNED_EN
  input  logic               op_unsigned,
`endif
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               ready,
  output logic               valid,
  output logic [2*WIDTH-1:0] product
);

  localparam int STEPS = WIDTH / 2;
`ifdef BOOTH_R4_UNSIGNED_EN
  // Zero-extended operands need one more multiplier digit (two more bits),
  // and an unsigned WIDTH-bit M behaves like a (WIDTH+1)-bit signed value,
  // so the accumulator carries one extra guard bit to keep the shift exact.
  localparam int AW = WIDTH + 3;
  localparam int QW = WIDTH + 2;
`else
  localparam int AW = WIDTH + 2;
  localparam int QW = WIDTH;
`endif
  localparam int CW = $clog2(STEPS + 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   m_ext;
  logic [QW-1:0]   q;
  logic            q_m1;
  logic [CW-1:0]   count;
`ifdef BOOTH_R4_UNSIGNED_EN
  logic            uns;
`endif

  logic [AW-1:0]      addend;
  logic [AW-1:0]      sum;
  logic [AW-1:0]      acc_nxt;
  logic [QW-1:0]      q_nxt;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [CW-1:0]      last_cnt;

  // Booth recode of {Q[1:0], q_m1}, add, then arithmetic shift right by 2.
  always_comb begin
    case ({q[1:0], q_m1})
      3'b001, 3'b010: addend = m_ext;
      3'b011:         addend = m_ext << 1;
      3'b100:         addend = ~(m_ext << 1) + AW'(1);
      3'b101, 3'b110: addend = ~m_ext + AW'(1);
      default:        addend = '0;
    endcase
    sum     = acc + addend;
    acc_nxt = {{2{sum[AW-1]}}, sum[AW-1:2]};
    q_nxt   = {sum[1:0], q[QW-1:2]};
`ifdef BOOTH_R4_UNSIGNED_EN
    // Signed ops leave the two sign-extension bits of Q at the bottom.
    if (uns) begin
      prod_nxt = {acc_nxt[WIDTH-3:0], q_nxt};
      last_cnt = CW'(STEPS);
    end else begin
      prod_nxt = {acc_nxt[WIDTH-1:0], q_nxt[QW-1:QW-WIDTH]};
      last_cnt = CW'(STEPS - 1);
    end
`else
    prod_nxt = {acc_nxt[WIDTH-1:0], q_nxt};
    last_cnt = CW'(STEPS - 1);
`endif
  end

  // Control FSM and datapath registers; product is captured on the final step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ready   <= 1'b1;
      valid   <= 1'b0;
      product <= '0;
      acc     <= '0;
      m_ext   <= '0;
      q       <= '0;
      q_m1    <= 1'b0;
      count   <= '0;
`ifdef BOOTH_R4_UNSIGNED_EN
      uns     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          if (start) begin
            acc   <= '0;
            q_m1  <= 1'b0;
            count <= '0;
            ready <= 1'b0;
            state <= RUN;
`ifdef BOOTH_R4_UNSIGNED_EN
            uns <= op_unsigned;
            if (op_unsigned) begin
              m_ext <= {{(AW-WIDTH){1'b0}}, multiplicand};
              q     <= {2'b00, multiplier};
            end else begin
              m_ext <= {{(AW-WIDTH){multiplicand[WIDTH-1]}}, multiplicand};
              q     <= {{2{multiplier[WIDTH-1]}}, multiplier};
            end
`else
            m_ext <= {{(AW-WIDTH){multiplicand[WIDTH-1]}}, multiplicand};
            q     <= multiplier;
`endif
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          q     <= q_nxt;
          q_m1  <= q[1];
          count <= count + CW'(1);
          if (count == last_cnt) begin
            product <= prod_nxt;
            valid   <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          valid <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          valid <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
